// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
// One memory-access port between a requesting master and the arbiter.
//   req    : access request, held with its payload until gnt
//   we     : 1 = write, 0 = read
//   addr   : word address (ADDR_W bits)
//   wdata  : write data
//   be     : byte enables for writes
//   gnt    : request accepted this cycle (combinational)
//   rvalid : read data valid, one cycle after a granted read
//   rdata  : read data
// Modports: master (requester side), slave (arbiter side).
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 14
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port data memory between the CPU data port (m0) and the
// JTAG debug port (m1). At most one access is granted per cycle. The CPU has
// fixed priority, except that the debug port wins a tie when the core is
// halted or after it has been denied STARVE_LIM consecutive cycles.
// Read data is returned to the master that owned the granted read.
//
// Ports:
//   clk_i          : clock, all state on rising edge
//   rst_ni         : asynchronous active-low reset
//   m0, m1         : master ports (slave modport), m0 = CPU, m1 = debug
//   dbg_halt_i     : core halted by debug, m1 gets absolute priority
//   m0_stall_o     : CPU request pending but not granted this cycle
//   ram_en_o       : memory strobe
//   ram_we_o       : memory write enable
//   ram_addr_o     : memory word address
//   ram_wdata_o    : memory write data
//   ram_be_o       : memory byte enables
//   ram_rdata_i    : memory read data, valid the cycle after a read strobe
//   conflict_cnt_o : saturating count of cycles where both masters requested
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int STARVE_LIM = 7
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mem_port_arbiter_if.slave m0,
    mem_port_arbiter_if.slave m1,
    input  logic              dbg_halt_i,
    output logic              m0_stall_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    output logic [3:0]        ram_be_o,
    input  logic [31:0]       ram_rdata_i,
    output logic [15:0]       conflict_cnt_o
);

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    logic [3:0]  wait_q, wait_d;
    logic        rd_pending_q, rd_pending_d;
    logic        rd_owner_q, rd_owner_d;
    logic [15:0] conflict_q, conflict_d;

    logic        both_req;
    logic        m0_gnt;
    logic        m1_gnt;

    // Grant select: m1 wins when it is alone, or on a tie while the core is
    // halted or once its starvation counter has reached the limit.
    assign both_req = m0.req & m1.req;
    assign m1_gnt   = m1.req & (~m0.req | dbg_halt_i | (wait_q == LIM));
    assign m0_gnt   = m0.req & ~m1_gnt;

    assign m0.gnt     = m0_gnt;
    assign m1.gnt     = m1_gnt;
    assign m0_stall_o = m0.req & ~m0_gnt;

    // Memory request mux; address/data follow m0 when nobody is granted,
    // which is harmless because the strobe is low then.
    assign ram_en_o    = m0_gnt | m1_gnt;
    assign ram_we_o    = (m0_gnt & m0.we) | (m1_gnt & m1.we);
    assign ram_addr_o  = m1_gnt ? m1.addr  : m0.addr;
    assign ram_wdata_o = m1_gnt ? m1.wdata : m0.wdata;
    assign ram_be_o    = m1_gnt ? m1.be    : m0.be;

    // Read return: both masters see the memory bus, rvalid selects the owner.
    assign m0.rdata  = ram_rdata_i;
    assign m1.rdata  = ram_rdata_i;
    assign m0.rvalid = rd_pending_q & ~rd_owner_q;
    assign m1.rvalid = rd_pending_q &  rd_owner_q;

    assign conflict_cnt_o = conflict_q;

    always_comb begin
        wait_d       = 4'd0;
        rd_pending_d = ram_en_o & ~ram_we_o;
        rd_owner_d   = m1_gnt;
        conflict_d   = conflict_q;

        // Counts consecutive denied cycles of m1, saturating at the limit;
        // any grant or dropped request restarts the count.
        if (m1.req & ~m1_gnt) begin
            wait_d = (wait_q == LIM) ? wait_q : wait_q + 4'd1;
        end

        if (both_req && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q       <= 4'd0;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
            conflict_q   <= 16'd0;
        end else begin
            wait_q       <= wait_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
            conflict_q   <= conflict_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives both master ports with directed and random traffic, models the
// arbitration rules and the memory contents, and compares grants, memory
// strobes, read returns and the conflict counter.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W = 14;
    localparam int LIM    = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              dbg_halt = 1'b0;
    logic              m0_stall;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_be;
    logic [31:0]       ram_rdata = 32'd0;
    logic [15:0]       conflict_cnt;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) m0_if ();
    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) m1_if ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIM(LIM)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .m0             (m0_if),
        .m1             (m1_if),
        .dbg_halt_i     (dbg_halt),
        .m0_stall_o     (m0_stall),
        .ram_en_o       (ram_en),
        .ram_we_o       (ram_we),
        .ram_addr_o     (ram_addr),
        .ram_wdata_o    (ram_wdata),
        .ram_be_o       (ram_be),
        .ram_rdata_i    (ram_rdata),
        .conflict_cnt_o (conflict_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Power-up contents of the memory, shared by the RAM and the model.
    function automatic logic [31:0] init_val(input int a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Single-port synchronous RAM with one-cycle read latency.
    logic [31:0] ram_mem [2**ADDR_W];
    bit          ram_wr  [2**ADDR_W];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                ram_mem[ram_addr] <= merge(ram_wr[ram_addr] ? ram_mem[ram_addr]
                                           : init_val(int'(ram_addr)), ram_wdata, ram_be);
                ram_wr[ram_addr]  <= 1'b1;
            end else begin
                ram_rdata <= ram_wr[ram_addr] ? ram_mem[ram_addr] : init_val(int'(ram_addr));
            end
        end
    end

    // Reference model state
    logic [31:0] model_mem [2**ADDR_W];
    int          denied   = 0;
    int          conf_mdl = 0;
    logic        last_g0, last_g1;

    typedef struct {
        int          due;
        logic        owner;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // One arbitration cycle: drive at the falling edge, check the
    // combinational response, then advance the model.
    task automatic step(input logic r0, input logic w0, input logic [ADDR_W-1:0] a0,
                        input logic [31:0] d0, input logic [3:0] b0,
                        input logic r1, input logic w1, input logic [ADDR_W-1:0] a1,
                        input logic [31:0] d1, input logic [3:0] b1,
                        input logic halt);
        logic              e0, e1, gw;
        logic [ADDR_W-1:0] ga;
        logic [31:0]       gd;
        logic [3:0]        gb;
        exp_t              e;
        @(negedge clk);
        m0_if.req = r0; m0_if.we = w0; m0_if.addr = a0; m0_if.wdata = d0; m0_if.be = b0;
        m1_if.req = r1; m1_if.we = w1; m1_if.addr = a1; m1_if.wdata = d1; m1_if.be = b1;
        dbg_halt  = halt;
        #2;
        if (r0 && r1) e1 = halt || (denied == LIM);
        else          e1 = r1;
        e0 = r0 && !e1;
        chk("m0_gnt", {31'd0, m0_if.gnt}, {31'd0, e0});
        chk("m1_gnt", {31'd0, m1_if.gnt}, {31'd0, e1});
        chk("m0_stall", {31'd0, m0_stall}, {31'd0, r0 && !e0});
        chk("ram_en", {31'd0, ram_en}, {31'd0, e0 || e1});
        chk("conflict_cnt", {16'd0, conflict_cnt}, conf_mdl);
        if (e0 || e1) begin
            ga = e1 ? a1 : a0;
            gw = e1 ? w1 : w0;
            gd = e1 ? d1 : d0;
            gb = e1 ? b1 : b0;
            chk("ram_we", {31'd0, ram_we}, {31'd0, gw});
            chk("ram_addr", {18'd0, ram_addr}, {18'd0, ga});
            if (gw) begin
                chk("ram_wdata", ram_wdata, gd);
                chk("ram_be", {28'd0, ram_be}, {28'd0, gb});
                model_mem[ga] = merge(model_mem[ga], gd, gb);
            end else if (rst_n) begin
                e.due = cyc + 1; e.owner = e1; e.data = model_mem[ga];
                exp_q.push_back(e);
            end
        end
        if (rst_n) begin
            if (r1 && !e1) denied = (denied < LIM) ? denied + 1 : LIM;
            else           denied = 0;
            if (r0 && r1 && conf_mdl < 65535) conf_mdl++;
        end
        last_g0 = e0;
        last_g1 = e1;
    endtask

    task automatic idle();
        step(0, 0, '0, 32'd0, 4'd0, 0, 0, '0, 32'd0, 4'd0, 0);
    endtask

    // Monitor: each cycle the expected read return is whatever is due now.
    initial begin
        exp_t e;
        logic ev, eo;
        forever begin
            @(posedge clk);
            #1;
            ev = (exp_q.size() != 0) && (exp_q[0].due == cyc);
            eo = ev ? exp_q[0].owner : 1'b0;
            chk("m0_rvalid", {31'd0, m0_if.rvalid}, {31'd0, ev && !eo});
            chk("m1_rvalid", {31'd0, m1_if.rvalid}, {31'd0, ev && eo});
            if (ev) begin
                e = exp_q.pop_front();
                chk(e.owner ? "m1_rdata" : "m0_rdata",
                    e.owner ? m1_if.rdata : m0_if.rdata, e.data);
            end
        end
    end

    initial begin
        logic              r0, w0, r1, w1, h0, h1, halt;
        logic [ADDR_W-1:0] a0, a1;
        logic [31:0]       d0, d1;
        logic [3:0]        b0, b1;
        int                m1_wins;

        for (int i = 0; i < 2**ADDR_W; i++) model_mem[i] = init_val(i);
        m0_if.req = 0; m0_if.we = 0; m0_if.addr = '0; m0_if.wdata = 0; m0_if.be = 0;
        m1_if.req = 0; m1_if.we = 0; m1_if.addr = '0; m1_if.wdata = 0; m1_if.be = 0;

        // Reset with requests low and random payloads
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++)
            step(0, $urandom_range(0, 1), ADDR_W'($urandom), $urandom, 4'($urandom),
                 0, $urandom_range(0, 1), ADDR_W'($urandom), $urandom, 4'($urandom), 0);
        chk("reset_conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
        rst_n = 1'b1;

        // First read after release
        step(1, 0, 14'h0010, 0, 0, 0, 0, '0, 0, 0, 0);
        idle();

        // Both masters read continuously: m1 wins one cycle in eight
        m1_wins = 0;
        for (int i = 0; i < 24; i++) begin
            step(1, 0, ADDR_W'(i), 0, 0, 1, 0, ADDR_W'(100 + i), 0, 0, 0);
            if (m1_if.gnt) m1_wins++;
        end
        chk("starve_m1_wins", m1_wins, 32'd3);

        // Debug halt gives m1 every tie; dropping it returns the grant to m0
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 14'h20, 0, 0, 1, 0, ADDR_W'(i), 0, 0, 1);
            chk("halt_m0_stall", {31'd0, m0_stall}, 32'd1);
        end
        step(1, 0, 14'h20, 0, 0, 1, 0, 14'h30, 0, 0, 0);
        chk("halt_drop_m0_gnt", {31'd0, m0_if.gnt}, 32'd1);
        idle();

        // Interleaved read returns followed by a write
        step(1, 0, 14'h5, 0, 0, 0, 0, '0, 0, 0, 0);
        step(0, 0, '0, 0, 0, 1, 0, 14'h6, 0, 0, 0);
        step(1, 1, 14'h7, 32'h1234_5678, 4'hF, 0, 0, '0, 0, 0, 0);
        idle();
        idle();

        // Partial write by m1, then read back by m0
        step(0, 0, '0, 0, 0, 1, 1, 14'h0100, 32'hDEAD_BEEF, 4'b0011, 0);
        step(1, 0, 14'h0100, 0, 0, 0, 0, '0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("wr_rd_low_half", {16'd0, m0_if.rdata[15:0]}, 32'h0000_BEEF);
        idle();

        // Random traffic, requests held with stable payload until granted
        h0 = 0; h1 = 0;
        r0 = 0; w0 = 0; a0 = '0; d0 = 0; b0 = 0;
        r1 = 0; w1 = 0; a1 = '0; d1 = 0; b1 = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!h0) begin
                r0 = ($urandom_range(0, 3) != 0); w0 = ($urandom_range(0, 2) == 0);
                a0 = ADDR_W'($urandom_range(0, 15)); d0 = $urandom; b0 = 4'($urandom);
            end
            if (!h1) begin
                r1 = ($urandom_range(0, 2) != 0); w1 = ($urandom_range(0, 2) == 0);
                a1 = ADDR_W'($urandom_range(0, 15)); d1 = $urandom; b1 = 4'($urandom);
            end
            halt = ($urandom_range(0, 9) == 0);
            step(r0, w0, a0, d0, b0, r1, w1, a1, d1, b1, halt);
            h0 = r0 && !last_g0;
            h1 = r1 && !last_g1;
        end
        idle();
        idle();

        // Reset lands in the rvalid cycle of a granted read
        step(1, 0, 14'h0042, 0, 0, 0, 0, '0, 0, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("reset_kills_m0_rvalid", {31'd0, m0_if.rvalid}, 32'd0);
        exp_q.delete();
        denied = 0;
        conf_mdl = 0;
        idle();
        rst_n = 1'b1;
        idle();
        idle();

        // Drive the conflict counter into saturation
        for (int i = 0; i < 65540; i++)
            step(1, 0, ADDR_W'(i), 0, 0, 1, 0, ADDR_W'(i + 7), 0, 0, 0);
        idle();
        chk("conflict_saturated", {16'd0, conflict_cnt}, 32'h0000_FFFF);
        idle();
        idle();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master, one-slave arbiter that shares the single-port physical data memory between the CPU data port (master 0) and the JTAG debug port (master 1). It sits between the datapath/debug stub and the memory, and grants at most one access per cycle. It routes registered read data back to the master whose read was granted, and gives the CPU fixed priority, bounded by a starvation limit for the debug port. It also exports a CPU stall for the hazard unit and a saturating conflict counter for debug visibility.

## Interface
- ADDR_W, 14, word-address width (memory holds 2^ADDR_W 32-bit words)
- STARVE_LIM, 7, consecutive denied cycles after which master 1 wins one tie; legal range 1..15
- CLK  in  1  system clock, all state on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- M0_REQ / M1_REQ  in  1  access request, held until granted
- M0_WE / M1_WE  in  1  1 = write, 0 = read
- M0_ADDR / M1_ADDR  in  ADDR_W  word address
- M0_WDATA / M1_WDATA  in  32  write data
- M0_BE / M1_BE  in  4  byte enables for writes
- M0_GNT / M1_GNT  out  1  request accepted this cycle (combinational)
- M0_RVALID / M1_RVALID  out  1  read data valid (registered)
- M0_RDATA / M1_RDATA  out  32  read data, driven from RAM_RDATA for both masters
- M0_STALL  out  1  M0_REQ & ~M0_GNT, to hazard unit
- DBG_HALT  in  1  core halted by debug; master 1 gets absolute priority
- RAM_EN, RAM_WE  out  1  memory strobe / write enable
- RAM_ADDR  out  ADDR_W  memory address
- RAM_WDATA  out  32 ; RAM_BE  out  4  write data / byte enables
- RAM_RDATA  in  32  memory read data, valid the cycle after a read strobe
- CONFLICT_CNT  out  16  saturating count of cycles where both masters requested

## Operation
- Grant select, combinational, at most one GNT per cycle:
  - Only one master requesting: that master is granted.
  - Both requesting, DBG_HALT=1: M1 is granted.
  - Both requesting, wait_cnt==STARVE_LIM: M1 is granted.
  - Both requesting otherwise: M0 is granted.
- RAM_EN = M0_GNT | M1_GNT. RAM_WE/ADDR/WDATA/BE are muxed from the granted master. When neither is granted, RAM_WE=0 and the data/address outputs are don't-care.
- wait_cnt (4 bits):
  - Increments, saturating at STARVE_LIM, each cycle with M1_REQ & ~M1_GNT.
  - Clears when M1_GNT=1 or M1_REQ=0.
- Read-return tracking:
  - rd_pending <= RAM_EN & ~RAM_WE.
  - rd_owner <= M1_GNT.
  - Mx_RVALID = rd_pending & (rd_owner==x).
  - Writes never produce RVALID.
- CONFLICT_CNT increments on M0_REQ & M1_REQ and holds at 16'hFFFF.
- Requests are not queued; an ungranted master retries by holding REQ and its payload stable.
- The arbiter does not check address ranges. Back-to-back accesses by the same or alternating masters are allowed every cycle.

## Timing
- Reset (RESET_N low, async): wait_cnt=0, rd_pending=0, rd_owner=0, CONFLICT_CNT=0, so M0_RVALID=M1_RVALID=0.
  - GNT/RAM_EN/STALL follow their combinational equations and are 0 whenever the REQs are 0.
  - A read granted in the cycle reset asserts is dropped; no RVALID follows deassertion.
- Read latency: grant in cycle t, Mx_RVALID and valid RDATA in cycle t+1 for exactly one cycle. A new grant in t+1 is legal (fully pipelined).
- Write: committed at the rising edge ending the grant cycle. A read of the same address granted in the next cycle returns the new data; the memory provides this, and the arbiter adds no bypass.
- Worst-case M1 wait with DBG_HALT=0 and M0 requesting continuously: STARVE_LIM denied cycles, granted on cycle STARVE_LIM+1. M0 is then stalled for that one cycle.
- DBG_HALT may change on any cycle. It affects the grant in the same cycle and does not reset wait_cnt.
- Simultaneous events:
  - M1 granted while wait_cnt saturated: wait_cnt clears to 0 on the next edge.
  - CONFLICT_CNT at 16'hFFFF plus a new conflict: it holds.

## Test plan
- Reset then idle: RESET_N low 3 cycles with random REQs held 0 -> all GNT/RVALID/RAM_EN 0, CONFLICT_CNT=0; M0 read 0x0010 after release -> M0_GNT same cycle, M0_RVALID one cycle later with RAM_RDATA.
- Conflict, default priority: both masters request reads continuously, STARVE_LIM=7 ->
  - M0 granted cycles 0..6, M1 granted cycle 7, M0_STALL=1 in cycle 7.
  - The pattern repeats every 8 cycles.
  - CONFLICT_CNT increments every cycle.
- DBG_HALT=1 with both masters requesting -> M1 granted every cycle, M0_STALL=1 throughout; dropping DBG_HALT -> M0 granted the same cycle.
- Interleaved read return: M0 read at t, M1 read at t+1, M0 write at t+2 -> M0_RVALID at t+1 only, M1_RVALID at t+2 only, no RVALID at t+3.
- Write-then-read: M1 writes 0xDEADBEEF with BE=4'b0011 to 0x0100, M0 reads 0x0100 the next cycle -> M0_RDATA low half 0xBEEF.
- Reset mid-read: RESET_N low in the cycle after a granted read, so the reset lands in the RVALID cycle -> RVALID is forced to 0 immediately (async) and does not reappear after release; force CONFLICT_CNT to saturate (65540 conflict cycles) -> it reads 16'hFFFF.
